exec_ctl: RTL and testbench

- Run/debug sequencer for the move-machine processor core.
- Owns the processor clock enable and the instruction-memory write port.
- A host issues commands over a valid/ready channel: load program words, run, halt, single/multi-step, set or clear a PC breakpoint.
- Sits between the host/debug link and the processor + instruction ROM/RAM; the processor advances its pc only in cycles where cpu_en=1.

---
 rtl/exec_ctl_if.sv | 35 +++
 rtl/exec_ctl.sv | 247 ++++++++++++++++++++++++
 tb/tb_exec_ctl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_ctl_if
//  Description : Host command channel of the run/debug sequencer.
//                Valid/ready handshake carrying an opcode and an operand.
//                  cmd_valid  host -> ctl   command present
//                  cmd_ready  ctl  -> host  command can be accepted
//                  cmd_op     host -> ctl   opcode (NOP..CLR_BP)
//                  cmd_data   host -> ctl   operand, IW bits
//                master : host side      slave : exec_ctl side
//  Revision    : 1.0  initial release
// ============================================================================
interface exec_ctl_if #(
    parameter int IW = 16
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [IW-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface : exec_ctl_if
`default_nettype wire

// File: rtl/exec_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : exec_ctl
//  Description : Run/debug sequencer for the move-machine processor core.
//                Owns the processor clock enable and the instruction-memory
//                write port; a host drives it through the command channel.
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                cmd            command channel (exec_ctl_if.slave)
//                pc             current processor pc (breakpoint compare only)
//                cpu_en         processor clock enable (combinational)
//                imem_we/addr/wdata  registered instruction-memory write port
//                halted         high while in HALTED
//                bp_hit         sticky: last stop was caused by the breakpoint
//                retired        count of cpu_en cycles, wraps modulo 2^CNT_W
//  Revision    : 1.0  initial release
// ============================================================================
module exec_ctl #(
    parameter int BITNESS = 8,
    parameter int IW      = 16,
    parameter int CNT_W   = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    exec_ctl_if.slave               cmd,
    input  wire logic [BITNESS-1:0] pc,
    output logic                    cpu_en,
    output logic                    imem_we,
    output logic [BITNESS-1:0]      imem_addr,
    output logic [IW-1:0]           imem_wdata,
    output logic                    halted,
    output logic                    bp_hit,
    output logic [CNT_W-1:0]        retired
);

    // ------------------------------------------------------------------
    // Opcodes and state encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_OP_NOP      = 3'd0;
    localparam logic [2:0] c_OP_SET_ADDR = 3'd1;
    localparam logic [2:0] c_OP_WRITE    = 3'd2;
    localparam logic [2:0] c_OP_RUN      = 3'd3;
    localparam logic [2:0] c_OP_HALT     = 3'd4;
    localparam logic [2:0] c_OP_STEP     = 3'd5;
    localparam logic [2:0] c_OP_SET_BP   = 3'd6;
    localparam logic [2:0] c_OP_CLR_BP   = 3'd7;

    localparam logic [1:0] c_ST_HALTED   = 2'd0;
    localparam logic [1:0] c_ST_RUNNING  = 2'd1;
    localparam logic [1:0] c_ST_STEPPING = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [BITNESS-1:0] r_load_addr;
    logic               r_bp_en;
    logic [BITNESS-1:0] r_bp_addr;
    logic               r_bp_hit;
    logic               r_skip_bp;
    logic [BITNESS-1:0] r_step_left;
    logic [CNT_W-1:0]   r_retired;
    logic               r_imem_we;
    logic [BITNESS-1:0] r_imem_addr;
    logic [IW-1:0]      r_imem_wdata;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_cmd_ready;
    logic               w_cpu_en;
    logic               w_accept;
    logic               w_bp_match;
    logic [BITNESS-1:0] w_operand;

    assign w_operand = cmd.cmd_data[BITNESS-1:0];
    assign w_accept  = cmd.cmd_valid & w_cmd_ready;

    // skip_bp masks the match for the first RUNNING cycle so that resuming
    // from a breakpoint executes the breakpointed instruction once.
    assign w_bp_match = r_bp_en & (pc == r_bp_addr) & ~r_skip_bp;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_HALTED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_HALTED: begin
                if (w_accept && cmd.cmd_op == c_OP_RUN) begin
                    w_state_nxt = c_ST_RUNNING;
                end else if (w_accept && cmd.cmd_op == c_OP_STEP) begin
                    w_state_nxt = c_ST_STEPPING;
                end
            end
            c_ST_RUNNING: begin
                // A breakpoint stop and a host HALT both land in HALTED;
                // bp_hit is resolved in the datapath.
                if (w_bp_match || (w_accept && cmd.cmd_op == c_OP_HALT)) begin
                    w_state_nxt = c_ST_HALTED;
                end
            end
            c_ST_STEPPING: begin
                if (r_step_left == BITNESS'(1)) begin
                    w_state_nxt = c_ST_HALTED;
                end
            end
            default: w_state_nxt = c_ST_HALTED;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_en    = 1'b0;
        w_cmd_ready = 1'b1;
        case (r_state)
            c_ST_HALTED: begin
                w_cpu_en    = 1'b0;
                w_cmd_ready = 1'b1;
            end
            c_ST_RUNNING: begin
                w_cpu_en    = ~w_bp_match;
                w_cmd_ready = 1'b1;
            end
            c_ST_STEPPING: begin
                // Breakpoints are ignored while stepping.
                w_cpu_en    = 1'b1;
                w_cmd_ready = 1'b0;
            end
            default: begin
                w_cpu_en    = 1'b0;
                w_cmd_ready = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_addr  <= '0;
            r_bp_en      <= 1'b0;
            r_bp_addr    <= '0;
            r_bp_hit     <= 1'b0;
            r_skip_bp    <= 1'b0;
            r_step_left  <= '0;
            r_retired    <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted WRITE.
            r_imem_we <= 1'b0;

            if (r_state == c_ST_RUNNING) begin
                r_skip_bp <= 1'b0;
            end

            if (r_state == c_ST_STEPPING) begin
                r_step_left <= r_step_left - BITNESS'(1);
            end

            if (w_accept) begin
                case (r_state)
                    c_ST_HALTED: begin
                        case (cmd.cmd_op)
                            c_OP_SET_ADDR: r_load_addr <= w_operand;
                            c_OP_WRITE: begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= r_load_addr;
                                r_imem_wdata <= cmd.cmd_data;
                                r_load_addr  <= r_load_addr + BITNESS'(1);
                            end
                            c_OP_RUN: begin
                                r_bp_hit  <= 1'b0;
                                r_skip_bp <= 1'b1;
                            end
                            c_OP_STEP: begin
                                // A step count of zero still executes one.
                                r_step_left <= (w_operand == '0) ? BITNESS'(1) : w_operand;
                                r_bp_hit    <= 1'b0;
                            end
                            c_OP_SET_BP: begin
                                r_bp_addr <= w_operand;
                                r_bp_en   <= 1'b1;
                            end
                            c_OP_CLR_BP: r_bp_en <= 1'b0;
                            c_OP_HALT, c_OP_NOP: begin
                            end
                            default: begin
                            end
                        endcase
                    end
                    c_ST_RUNNING: begin
                        // Only breakpoint edits act while running; everything
                        // else is consumed, so imem is never written here.
                        if (cmd.cmd_op == c_OP_SET_BP) begin
                            r_bp_addr <= w_operand;
                            r_bp_en   <= 1'b1;
                        end else if (cmd.cmd_op == c_OP_CLR_BP) begin
                            r_bp_en <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // Breakpoint stop wins over a simultaneous HALT for bp_hit.
            if (r_state == c_ST_RUNNING && w_bp_match) begin
                r_bp_hit <= 1'b1;
            end

            if (w_cpu_en) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd.cmd_ready = w_cmd_ready;
    assign cpu_en        = w_cpu_en;
    assign halted        = (r_state == c_ST_HALTED);
    assign bp_hit        = r_bp_hit;
    assign retired       = r_retired;
    assign imem_we       = r_imem_we;
    assign imem_addr     = r_imem_addr;
    assign imem_wdata    = r_imem_wdata;

endmodule : exec_ctl
`default_nettype wire

// File: tb/tb_exec_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_ctl
//  Description : Self-checking bench for exec_ctl. Expected imem writes are
//                queued when WRITE commands are issued and popped when the
//                DUT pulses imem_we; other checks use fixed expectations.
//                A small pc model increments whenever cpu_en is high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exec_ctl;

    localparam int BITNESS = 8;
    localparam int IW      = 16;
    localparam int CNT_W   = 4;

    localparam logic [2:0] c_OP_NOP      = 3'd0;
    localparam logic [2:0] c_OP_SET_ADDR = 3'd1;
    localparam logic [2:0] c_OP_WRITE    = 3'd2;
    localparam logic [2:0] c_OP_RUN      = 3'd3;
    localparam logic [2:0] c_OP_HALT     = 3'd4;
    localparam logic [2:0] c_OP_STEP     = 3'd5;
    localparam logic [2:0] c_OP_SET_BP   = 3'd6;

    logic               clk;
    logic               rst;
    logic [BITNESS-1:0] pc_m;
    logic               pc_clr;
    logic               cpu_en;
    logic               imem_we;
    logic [BITNESS-1:0] imem_addr;
    logic [IW-1:0]      imem_wdata;
    logic               halted;
    logic               bp_hit;
    logic [CNT_W-1:0]   retired;

    int n_vec;
    int n_err;
    int en_cycles;

    // Expected imem writes: {addr, data}
    logic [BITNESS+IW-1:0] wr_q[$];

    exec_ctl_if #(.IW(IW)) bus ();

    exec_ctl #(
        .BITNESS (BITNESS),
        .IW      (IW),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus.slave),
        .pc         (pc_m),
        .cpu_en     (cpu_en),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Processor pc model: advances on every enabled cycle.
    always @(posedge clk or posedge rst) begin
        if (rst)         pc_m <= '0;
        else if (pc_clr) pc_m <= '0;
        else if (cpu_en) pc_m <= pc_m + 8'd1;
    end

    always @(posedge clk) begin
        if (!rst && cpu_en) en_cycles <= en_cycles + 1;
    end

    // Scoreboard consumer for the instruction-memory write port.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (wr_q.size() == 0) begin
                check("imem_we_unexpected", 32'(imem_we), 32'd0);
            end else begin
                logic [BITNESS+IW-1:0] e;
                e = wr_q.pop_front();
                check("imem_addr", 32'(imem_addr), 32'(e[BITNESS+IW-1:IW]));
                check("imem_wdata", 32'(imem_wdata), 32'(e[IW-1:0]));
            end
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [15:0] data);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        for (int i = 0; i < 64; i++) begin
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        check("cmd_ready_at_issue", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = c_OP_NOP;
    endtask

    task automatic wait_halted(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        int e0;
        n_vec = 0;
        n_err = 0;
        en_cycles = 0;
        rst = 1'b1;
        pc_clr = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = c_OP_NOP;
        bus.cmd_data  = '0;

        // ---------------- reset state ----------------
        #23;
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- 1: load, no run ----------------
        send_cmd(c_OP_SET_ADDR, 16'h00FE);
        wr_q.push_back({8'hFE, 16'h1111});
        send_cmd(c_OP_WRITE, 16'h1111);
        wr_q.push_back({8'hFF, 16'h2222});
        send_cmd(c_OP_WRITE, 16'h2222);
        wr_q.push_back({8'h00, 16'h3333});
        send_cmd(c_OP_WRITE, 16'h3333);
        repeat (3) @(negedge clk);
        check("load_q_drained", 32'(wr_q.size()), 32'd0);
        check("load_en_cycles", 32'(en_cycles), 32'd0);
        check("load_retired", 32'(retired), 32'd0);
        check("load_halted", 32'(halted), 32'd1);

        // ---------------- 2: step ----------------
        send_cmd(c_OP_STEP, 16'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("step_cpu_en", 32'(cpu_en), 32'd1);
            check("step_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge clk);
        check("step_done_halted", 32'(halted), 32'd1);
        check("step_done_cpu_en", 32'(cpu_en), 32'd0);
        check("step3_retired", 32'(retired), 32'd3);
        send_cmd(c_OP_STEP, 16'd0);
        @(negedge clk);
        check("step0_cpu_en", 32'(cpu_en), 32'd1);
        @(negedge clk);
        check("step0_halted", 32'(halted), 32'd1);
        check("step0_retired", 32'(retired), 32'd4);

        // ---------------- 3: breakpoint ----------------
        @(negedge clk);
        pc_clr = 1'b1;
        @(negedge clk);
        pc_clr = 1'b0;
        send_cmd(c_OP_SET_BP, 16'h0005);
        e0 = en_cycles;
        send_cmd(c_OP_RUN, 16'h0000);
        wait_halted("bp_stop_halted");
        check("bp_stop_pc", 32'(pc_m), 32'h05);
        check("bp_stop_cpu_en", 32'(cpu_en), 32'd0);
        check("bp_stop_bp_hit", 32'(bp_hit), 32'd1);
        check("bp_stop_cycles", 32'(en_cycles - e0), 32'd5);
        check("bp_stop_retired", 32'(retired), 32'd9);
        send_cmd(c_OP_RUN, 16'h0000);
        @(negedge clk);
        check("resume_bp_hit", 32'(bp_hit), 32'd0);
        check("resume_skip_cpu_en", 32'(cpu_en), 32'd1);
        repeat (3) @(negedge clk);
        check("resume_pc", 32'(pc_m), 32'h08);
        check("resume_running", 32'(halted), 32'd0);

        // ---------------- 4: halt race, WRITE while running ----------------
        send_cmd(c_OP_WRITE, 16'hBEEF);
        send_cmd(c_OP_SET_BP, 16'h0010);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pc_m == 8'h10) break;
        end
        check("race_pc_reached", 32'(pc_m), 32'h10);
        check("race_cpu_en", 32'(cpu_en), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = c_OP_HALT;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = c_OP_NOP;
        check("race_halted", 32'(halted), 32'd1);
        check("race_bp_hit", 32'(bp_hit), 32'd1);

        // ---------------- 5: async reset mid-step ----------------
        send_cmd(c_OP_SET_BP, 16'h0003);
        send_cmd(c_OP_STEP, 16'd5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cpu_en", 32'(cpu_en), 32'd0);
        check("arst_retired", 32'(retired), 32'd0);
        check("arst_halted", 32'(halted), 32'd1);
        check("arst_ready", 32'(bus.cmd_ready), 32'd1);
        check("arst_imem_wdata", 32'(imem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        e0 = en_cycles;
        send_cmd(c_OP_RUN, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        check("arst_run_running", 32'(halted), 32'd0);
        check("arst_run_bp_hit", 32'(bp_hit), 32'd0);
        check("arst_run_pc", 32'(pc_m), 32'd10);
        check("arst_run_cycles", 32'(en_cycles - e0), 32'd10);
        send_cmd(c_OP_HALT, 16'h0000);
        @(negedge clk);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_cpu_en", 32'(cpu_en), 32'd0);

        // ---------------- 6: counter wrap ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e0 = en_cycles;
        send_cmd(c_OP_STEP, 16'd17);
        wait_halted("wrap_halted");
        check("wrap_cycles", 32'(en_cycles - e0), 32'd17);
        check("wrap_retired", 32'(retired), 32'd1);

        repeat (2) @(negedge clk);
        check("final_q_empty", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_exec_ctl
`default_nettype wire
